// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes and the LSU state type.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store data replication,
// misalign/illegal detection on the request side, and load lane extraction
// with sign/zero extension on the response side.
module lsu_align
   import riscv_pkg::*;
#(
   parameter int MISALIGN_CHECK = 1
) (
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [1:0]  offset,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic        fault,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic        legal;
   logic        misaligned;
   logic [31:0] lane;

   // Request side: width decode, lane placement and fault detection; the offset is
   // forced to the natural alignment so that unchecked accesses behave as aligned.
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      offset     = addr_lo;
      be         = 4'b0000;
      lane_wdata = wdata;
      case (funct3)
         F3_B, F3_BU: begin
            legal      = !we || (funct3 == F3_B);
            offset     = addr_lo;
            be         = 4'b0001 << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            legal      = !we || (funct3 == F3_H);
            misaligned = addr_lo[0];
            offset     = {addr_lo[1], 1'b0};
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
         end
         F3_W: begin
            legal      = 1'b1;
            misaligned = (addr_lo != 2'b00);
            offset     = 2'b00;
            be         = 4'b1111;
            lane_wdata = wdata;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
      fault = !legal || ((MISALIGN_CHECK != 0) && misaligned);
   end

   // Response side: shift the addressed lane down to bit 0, then extend by width/sign.
   always_comb begin
      lane = rdata >> {ld_offset, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   ld_data = {24'h000000, lane[7:0]};
         F3_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   ld_data = {16'h0000, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one op at a time from the core, issues a single
// word-aligned memory request, and returns one response pulse per op.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int MISALIGN_CHECK = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   lsu_state_t  state;
   lsu_state_t  next_state;

   logic [29:0] word_addr_q;
   logic [1:0]  offset_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [1:0]  offset;
   logic [3:0]  be;
   logic [31:0] lane_wdata;
   logic        fault;
   logic [31:0] ld_data;
   logic        accept;

   assign accept = (state == IDLE) && req_valid;

   lsu_align #(
      .MISALIGN_CHECK(MISALIGN_CHECK)
   ) u_align (
      .we         (req_we),
      .funct3     (req_funct3),
      .addr_lo    (req_addr[1:0]),
      .wdata      (req_wdata),
      .offset     (offset),
      .be         (be),
      .lane_wdata (lane_wdata),
      .fault      (fault),
      .ld_funct3  (funct3_q),
      .ld_offset  (offset_q),
      .rdata      (mem_rdata),
      .ld_data    (ld_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; faulting ops skip the memory entirely and respond next cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid) next_state = fault ? RESP : REQ;
         REQ:  if (mem_ready) next_state = we_q ? RESP : WAIT;
         WAIT: if (mem_rvalid) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Op capture at accept and load data capture in WAIT; the memory-side fields are
   // left untouched by a faulting op since it never reaches the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_addr_q <= '0;
         offset_q    <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            err_q   <= fault;
            rdata_q <= '0;
            if (!fault) begin
               word_addr_q <= req_addr[31:2];
               offset_q    <= offset;
               be_q        <= be;
               wdata_q     <= lane_wdata;
               we_q        <= req_we;
               funct3_q    <= req_funct3;
            end
         end
         if ((state == WAIT) && mem_rvalid) begin
            rdata_q <= ld_data;
         end
      end
   end

   // Outputs decoded from state; response fields read as zero outside RESP.
   always_comb begin
      req_ready = (state == IDLE);
      mem_valid = (state == REQ);
      rsp_valid = (state == RESP);
      rsp_err   = (state == RESP) && err_q;
      rsp_rdata = (state == RESP) ? rdata_q : 32'h0000_0000;
      mem_addr  = {word_addr_q, 2'b00};
      mem_be    = be_q;
      mem_we    = we_q;
      mem_wdata = wdata_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops,
// all checked against a byte-level reference model of RV32I load/store behaviour.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(
      .MISALIGN_CHECK(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // 10 ns clock; the DUT acts on the rising edge, the bench works on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something deadlocks the sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Every output must be at its idle/zero value while reset is applied.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
      checkOutput({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
      checkOutput({tag, "_mem_be"},    32'(mem_be),    32'd0);
      checkOutput({tag, "_mem_we"},    32'(mem_we),    32'd0);
      checkOutput({tag, "_mem_addr"},  mem_addr,       32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata,      32'd0);
   endtask

   // One complete op: predict the result from the RV32I rules, play the memory side
   // with the requested grant and read-data delays, and check everything on the way.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int rdy_dly, input int rv_dly);
      bit              legal;
      bit              err;
      bit              done;
      int              size;
      int              off;
      int              lat;
      int              rsp_cnt;
      int              mv_cnt;
      int              grant_cyc;
      logic [31:0]     exp_addr;
      logic [3:0]      exp_be;
      logic [31:0]     exp_wdata;
      logic [31:0]     exp_rdata;
      longint unsigned v;
      longint unsigned mask;

      // Reference model: sizes in bytes, lane offsets and extension from plain arithmetic.
      legal     = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      size      = 1 << f3[1:0];
      off       = int'(addr % 4);
      err       = !legal || ((off % size) != 0);
      exp_addr  = addr & 32'hFFFF_FFFC;
      exp_be    = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) begin
         exp_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
      if (err || we) begin
         exp_rdata = 32'd0;
      end else begin
         v    = 64'(rdata) >> (8 * off);
         mask = (64'd1 << (8 * size)) - 1;
         v    = v & mask;
         if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 64'd1) != 0)) v = v | ~mask;
         exp_rdata = v[31:0];
      end
      lat = err ? 1 : (we ? 2 + rdy_dly : 3 + rdy_dly + rv_dly);

      done      = 1'b0;
      rsp_cnt   = 0;
      mv_cnt    = 0;
      grant_cyc = -1;

      @(negedge clk);
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      mem_ready  = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(posedge clk);

      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         if (rsp_cnt > 0) begin
            checkOutput("rsp_single_pulse", 32'(rsp_valid), 32'd0);
            checkOutput("req_ready_after", 32'(req_ready), 32'd1);
            done = 1'b1;
         end else begin
            checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
               rsp_cnt = 1;
               checkOutput("latency", 32'(cyc), 32'(lat));
               checkOutput("rsp_err", 32'(rsp_err), 32'(err));
               checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            end
            if (mem_valid) begin
               mv_cnt++;
               checkOutput("mem_addr", mem_addr, exp_addr);
               checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
               checkOutput("mem_we", 32'(mem_we), 32'(we));
               if (we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
            end
         end

         // Scramble the core side; the DUT must be working from its registered copy.
         req_valid  = 1'b0;
         req_we     = 1'($urandom_range(0, 1));
         req_funct3 = 3'($urandom_range(0, 7));
         req_addr   = $urandom;
         req_wdata  = $urandom;

         // Memory side: grant after rdy_dly cycles, return data rv_dly cycles after grant,
         // and toss noise onto mem_ready/mem_rvalid wherever the DUT must ignore it.
         if (mem_valid) begin
            mem_ready  = (mv_cnt > rdy_dly);
            if (mem_ready) grant_cyc = cyc;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
         end else if (grant_cyc >= 0 && !we && cyc == grant_cyc + 1 + rv_dly) begin
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end else if (grant_cyc >= 0 && !we && cyc <= grant_cyc + rv_dly) begin
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end else begin
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
         end
      end

      if (rsp_cnt == 0) checkOutput("rsp_timeout", 32'd0, 32'd1);
      checkOutput("mem_valid_cycles", 32'(mv_cnt), err ? 32'd0 : 32'(rdy_dly + 1));
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   // Main sequence: reset, directed scenarios, randomized ops, reset during WAIT.
   initial begin
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;

      #1 rst_n = 1'b0;
      #2 checkResetState("reset");
      repeat (2) @(negedge clk);
      checkResetState("reset_held");
      rst_n = 1'b1;

      // Directed scenarios
      applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
      applyStimulus(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
      applyStimulus(1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 0);
      applyStimulus(1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 0);
      applyStimulus(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0, 0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 0);
      applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0);
      applyStimulus(1'b1, 3'b001, 32'h0000_0106, 32'h0000_C3D4, 32'h0, 0, 0);
      applyStimulus(1'b1, 3'b011, 32'h0000_0100, 32'h1111_2222, 32'h0, 0, 0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, 3, 2);

      // Randomized ops, biased toward legal widths and aligned addresses
      for (int n = 0; n < 150; n++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                          : ((n % 5 == 0) ? 3'b010 : 3'($urandom_range(0, 5)));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         applyStimulus(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset while a load sits in WAIT; the late read data must be dropped
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0300;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rst_pre_req", 32'(mem_valid), 32'd1);
      mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("rst_in_wait_mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("rst_in_wait_req_ready", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1 checkResetState("mid_reset");
      @(negedge clk);
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      repeat (3) begin
         @(negedge clk);
         checkOutput("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
         checkOutput("late_rvalid_ready", 32'(req_ready), 32'd1);
      end
      mem_rvalid = 1'b0;

      // Normal operation resumes after the abandoned op
      applyStimulus(1'b0, 3'b001, 32'h0000_0502, 32'h0, 32'h8001_7FFF, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
